// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared widths and FSM state encoding for the AES core arbiter.
package aes_arb_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam int STAT_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the lowest requesting index at or after ptr (wrapping); combinational.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);
    // Scan offsets from the far end so the nearest requester after ptr wins last.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                any = 1'b1;
                idx = W'((int'(ptr) + i) % N);
            end
        end
    end
    assign grant = any ? N'(1) << idx : '0;
endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sharing of one AES128 core among NUM_REQ requesters.
// Define AES_ARB_STATS_EN to add the stat_ops/stat_busy counters.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 4,
    parameter int SRC_W = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key,
    input  logic [NUM_REQ*ID_W-1:0]        req_id,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [AES_BLOCK_W-1:0]         rsp_data,
    output logic [SRC_W-1:0]               rsp_src,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           core_ce,
    output logic [AES_BLOCK_W-1:0]         core_data_in,
    output logic [AES_BLOCK_W-1:0]         core_key,
    input  logic [AES_BLOCK_W-1:0]         core_data_out,
    input  logic                           core_done
`ifdef AES_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]              stat_ops,
    output logic [STAT_W-1:0]              stat_busy
`endif
);
    state_t state;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] idx;
    logic [NUM_REQ-1:0] grant;
    logic any;
    logic take;

    rr_arbiter #(.N(NUM_REQ), .W(SRC_W)) u_rr (
        .req(req_valid),
        .ptr(ptr),
        .grant(grant),
        .idx(idx),
        .any(any)
    );

    // A core still showing done from the last operation must clear before a new grant.
    assign take = state == IDLE && any && !core_done && !reset;
    assign req_ready = take ? grant : '0;
    assign core_ce = state == RUN;
    assign rsp_valid = state == RESP;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            core_data_in <= '0;
            core_key <= '0;
            rsp_data <= '0;
            rsp_src <= '0;
            rsp_id <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    core_data_in <= req_data[int'(idx) * AES_BLOCK_W +: AES_BLOCK_W];
                    core_key <= req_key[int'(idx) * AES_BLOCK_W +: AES_BLOCK_W];
                    rsp_id <= req_id[int'(idx) * ID_W +: ID_W];
                    rsp_src <= idx;
                    ptr <= int'(idx) == NUM_REQ - 1 ? '0 : idx + 1'b1;
                    state <= RUN;
                end
                RUN: if (core_done) begin
                    rsp_data <= core_data_out;
                    state <= DRAIN;
                end
                DRAIN: state <= RESP;
                RESP: if (rsp_ready) state <= IDLE;
            endcase
        end
    end

`ifdef AES_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_ops <= '0;
            stat_busy <= '0;
        end else begin
            if (state == RESP && rsp_ready && stat_ops != '1) stat_ops <= stat_ops + 1'b1;
            if (state == RUN && stat_busy != '1) stat_busy <= stat_busy + 1'b1;
        end
    end
`endif
endmodule
